fb_scanout: RTL

Framebuffer scan-out stage sitting between the video timing generator and the TMDS encoder in the HDMI transmit path. It walks the low-resolution SRAM framebuffer in raster order, producing `sramAddress` and consuming `sramRdData`. Each stored pixel is upscaled by an integer power-of-two factor in both axes. The 6-bit RGB222 pixels are expanded to RGB888, and hsync/vsync/de are re-aligned so they arrive at the encoder in step with the pixel colour.

---
 rtl/fb_scanout_pkg.sv | 29 ++
 rtl/sig_delay.sv | 40 ++++
 rtl/fb_scanout.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fb_scanout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_scanout_pkg
// Description : Shared constants and helpers for the framebuffer scan-out.
//               Holds the default geometry, the RGB222 field offsets and the
//               2-bit to 8-bit channel expansion function.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_scanout_pkg;

    localparam int c_FB_WIDTH    = 160;
    localparam int c_FB_HEIGHT   = 120;
    localparam int c_SCALE_SHIFT = 2;
    localparam int c_ADDR_W      = 15;
    localparam int c_PIX_W       = 6;
    localparam int c_RD_LATENCY  = 1;

    // Bit offsets of the 2-bit channels inside a stored pixel {r, g, b}
    localparam int c_RED_LSB     = 4;
    localparam int c_GREEN_LSB   = 2;
    localparam int c_BLUE_LSB    = 0;

    // Replicating the 2-bit value fills the byte evenly: 0,0x55,0xAA,0xFF
    function automatic logic [7:0] expand2to8(input logic [1:0] c);
        return {4{c}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sig_delay.sv
`default_nettype none
// ============================================================================
// Module      : sig_delay
// Description : Fixed-depth shift register used to carry sideband signals
//               alongside a data pipeline.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset, clears every stage
//               i_data - WIDTH-bit input
//               o_data - i_data delayed by DEPTH cycles (DEPTH >= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module sig_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
// Module      : fb_scanout
// Description : Framebuffer scan-out between the video timing generator and
//               the TMDS encoder. Walks the low-resolution framebuffer in
//               raster order with power-of-two pixel/line replication,
//               expands RGB222 to RGB888 and delays the syncs to match.
// Ports       : pixelClk              - pixel clock
//               resetN                - asynchronous active-low reset
//               inHsync/inVsync/inDe  - timing generator inputs
//               sramAddress           - registered framebuffer read address
//               sramRdData            - read data, RD_LATENCY after address
//               outHsync/outVsync/outDe - inputs delayed by RD_LATENCY+2
//               outRed/outGreen/outBlue - expanded colour, 0 outside de
//               lineOverrun           - sticky: a line had too many de cycles
// Revision    : 1.0 - initial release
// ============================================================================
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int FB_WIDTH    = c_FB_WIDTH,
    parameter int FB_HEIGHT   = c_FB_HEIGHT,
    parameter int SCALE_SHIFT = c_SCALE_SHIFT,
    parameter int ADDR_W      = c_ADDR_W,
    parameter int PIX_W       = c_PIX_W,
    parameter int RD_LATENCY  = c_RD_LATENCY
) (
    input  logic              pixelClk,
    input  logic              resetN,
    input  logic              inHsync,
    input  logic              inVsync,
    input  logic              inDe,
    output logic [ADDR_W-1:0] sramAddress,
    input  logic [PIX_W-1:0]  sramRdData,
    output logic              outHsync,
    output logic              outVsync,
    output logic              outDe,
    output logic [7:0]        outRed,
    output logic [7:0]        outGreen,
    output logic [7:0]        outBlue,
    output logic              lineOverrun
);

    localparam int c_FBX_W     = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1;
    localparam int c_FBY_W     = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
    // Sideband delay up to the output register; the output register itself
    // supplies the final cycle of the RD_LATENCY+2 total.
    localparam int c_DLY_DEPTH = RD_LATENCY + 1;

    logic                   r_vsyncPrev;
    logic                   r_dePrev;
    logic [SCALE_SHIFT-1:0] r_subX;
    logic [SCALE_SHIFT-1:0] r_subY;
    logic [c_FBX_W-1:0]     r_fbX;
    logic [c_FBY_W-1:0]     r_fbY;
    logic [ADDR_W-1:0]      r_lineBase;
    logic [ADDR_W-1:0]      r_sramAddress;
    logic                   r_lineFull;     // last stored pixel fully replicated
    logic                   r_lineOverrun;

    logic                   w_frameStart;
    logic                   w_lineEnd;
    logic                   w_lastX;
    logic                   w_lastY;
    logic [2:0]             w_syncDly;      // {hsync, vsync, de}

    logic                   r_outHsync;
    logic                   r_outVsync;
    logic                   r_outDe;
    logic [7:0]             r_outRed;
    logic [7:0]             r_outGreen;
    logic [7:0]             r_outBlue;

    assign w_frameStart = inVsync & ~r_vsyncPrev;
    assign w_lineEnd    = r_dePrev & ~inDe;
    assign w_lastX      = (r_fbX == c_FBX_W'(FB_WIDTH - 1));
    assign w_lastY      = (r_fbY == c_FBY_W'(FB_HEIGHT - 1));

    // Address generator
    always_ff @(posedge pixelClk or negedge resetN) begin
        if (!resetN) begin
            r_vsyncPrev   <= 1'b0;
            r_dePrev      <= 1'b0;
            r_subX        <= '0;
            r_subY        <= '0;
            r_fbX         <= '0;
            r_fbY         <= '0;
            r_lineBase    <= '0;
            r_sramAddress <= '0;
            r_lineFull    <= 1'b0;
            r_lineOverrun <= 1'b0;
        end else begin
            r_vsyncPrev <= inVsync;
            r_dePrev    <= inDe;
            if (w_frameStart) begin
                r_subX        <= '0;
                r_subY        <= '0;
                r_fbX         <= '0;
                r_fbY         <= '0;
                r_lineBase    <= '0;
                r_lineFull    <= 1'b0;
                r_lineOverrun <= 1'b0;
                // Address from the cleared counters
                if (inDe) begin
                    r_sramAddress <= '0;
                end
            end else if (inDe) begin
                r_sramAddress <= r_lineBase + ADDR_W'(r_fbX);
                // Once the last stored pixel has had its full replication,
                // any further de cycle is an overrun and the address holds.
                if (r_lineFull) begin
                    r_lineOverrun <= 1'b1;
                end else begin
                    r_subX <= r_subX + 1'b1;
                    if (&r_subX) begin
                        if (w_lastX) begin
                            r_lineFull <= 1'b1;
                        end else begin
                            r_fbX <= r_fbX + 1'b1;
                        end
                    end
                end
            end else if (w_lineEnd) begin
                r_subX     <= '0;
                r_fbX      <= '0;
                r_lineFull <= 1'b0;
                r_subY     <= r_subY + 1'b1;
                // Past the last stored row the row repeats
                if ((&r_subY) && !w_lastY) begin
                    r_fbY      <= r_fbY + 1'b1;
                    r_lineBase <= r_lineBase + ADDR_W'(FB_WIDTH);
                end
            end
        end
    end

    sig_delay #(
        .DEPTH (c_DLY_DEPTH),
        .WIDTH (3)
    ) u_syncDelay (
        .clk    (pixelClk),
        .rst_n  (resetN),
        .i_data ({inHsync, inVsync, inDe}),
        .o_data (w_syncDly)
    );

    // Expansion and output register: read data is valid in the same cycle
    // the delayed de reaches the end of the sideband delay.
    always_ff @(posedge pixelClk or negedge resetN) begin
        if (!resetN) begin
            r_outHsync <= 1'b0;
            r_outVsync <= 1'b0;
            r_outDe    <= 1'b0;
            r_outRed   <= '0;
            r_outGreen <= '0;
            r_outBlue  <= '0;
        end else begin
            r_outHsync <= w_syncDly[2];
            r_outVsync <= w_syncDly[1];
            r_outDe    <= w_syncDly[0];
            if (w_syncDly[0]) begin
                r_outRed   <= expand2to8(sramRdData[c_RED_LSB   +: 2]);
                r_outGreen <= expand2to8(sramRdData[c_GREEN_LSB +: 2]);
                r_outBlue  <= expand2to8(sramRdData[c_BLUE_LSB  +: 2]);
            end else begin
                r_outRed   <= '0;
                r_outGreen <= '0;
                r_outBlue  <= '0;
            end
        end
    end

    assign sramAddress = r_sramAddress;
    assign lineOverrun = r_lineOverrun;
    assign outHsync    = r_outHsync;
    assign outVsync    = r_outVsync;
    assign outDe       = r_outDe;
    assign outRed      = r_outRed;
    assign outGreen    = r_outGreen;
    assign outBlue     = r_outBlue;

endmodule
`default_nettype wire
